// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// EX operand forwarding codes and the hard-wired zero register.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_WB = 2'b01;
    localparam logic [1:0] FWD_ME = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // ME result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       me_regwr,
        input logic [4:0] me_rd,
        input logic       wb_regwr,
        input logic [4:0] wb_rd
    );
        if (me_regwr && me_rd != REG_ZERO && me_rd == src)
            return FWD_ME;
        else if (wb_regwr && wb_rd != REG_ZERO && wb_rd == src)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_ctrl_fwd_unit.sv
// EX-stage operand forwarding selects; purely combinational.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] me_rd,
    input  logic       me_regwr,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwr,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    assign fwd_a = fwd_sel(ex_rs, me_regwr, me_rd, wb_regwr, wb_rd);
    assign fwd_b = fwd_sel(ex_rt, me_regwr, me_rd, wb_regwr, wb_rd);

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for a 5-stage pipeline: stage enables and
// flushes, forwarding selects, data-memory handshake and stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwr,
    input  logic             ex_mem2reg,
    input  logic             ex_branch_taken,
    input  logic [4:0]       me_rd,
    input  logic             me_regwr,
    input  logic             me_mem2reg,
    input  logic             me_memwr,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwr,
    input  logic             wb_halt,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_me_en,
    output logic             me_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             me_wb_flush,
    output logic             dmem_req,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    state_t     state;
    logic       mem;
    logic       load_use;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    assign mem = me_mem2reg | me_memwr;

    assign load_use = ex_mem2reg && ex_regwr && ex_rd != REG_ZERO &&
                      ((id_uses_rs && id_rs == ex_rd) ||
                       (id_uses_rt && id_rt == ex_rd));

    fwd_unit u_fwd (
        .ex_rs    (ex_rs),
        .ex_rt    (ex_rt),
        .me_rd    (me_rd),
        .me_regwr (me_regwr),
        .wb_rd    (wb_rd),
        .wb_regwr (wb_regwr),
        .fwd_a    (fwd_a_raw),
        .fwd_b    (fwd_b_raw)
    );

    assign fwd_a = rst ? FWD_RF : fwd_a_raw;
    assign fwd_b = rst ? FWD_RF : fwd_b_raw;

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_me_en    = 1'b1;
        me_wb_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        me_wb_flush = 1'b0;
        dmem_req    = 1'b0;
        halted      = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_me_en    = 1'b0;
            me_wb_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            me_wb_flush = 1'b1;
        end else begin
            case (state)
                HALTED: begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    id_ex_en = 1'b0;
                    ex_me_en = 1'b0;
                    me_wb_en = 1'b0;
                    halted   = 1'b1;
                end
                MEM_WAIT: begin
                    dmem_req = 1'b1;
                    if (!dmem_ack) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_en    = 1'b0;
                        ex_me_en    = 1'b0;
                        me_wb_flush = 1'b1;
                    end
                end
                default: begin
                    dmem_req = mem;
                    if (mem && !dmem_ack) begin
                        // freeze the front, drain a bubble into WB
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_en    = 1'b0;
                        ex_me_en    = 1'b0;
                        me_wb_flush = 1'b1;
                    end else if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (wb_halt)
                        state <= HALTED;
                    else if (mem && !dmem_ack)
                        state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (dmem_ack)
                        state <= RUN;
                end
                HALTED:  state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (!pc_en && state != HALTED && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl; a second 4-bit-counter instance
// shares all inputs to exercise counter saturation.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, me_rd, wb_rd;
    logic       id_uses_rs, id_uses_rt, ex_regwr, ex_mem2reg, ex_branch_taken;
    logic       me_regwr, me_mem2reg, me_memwr, wb_regwr, wb_halt, dmem_ack;

    logic        pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en;
    logic        if_id_flush, id_ex_flush, me_wb_flush, dmem_req, halted;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cycles;

    logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_me_en, s_me_wb_en;
    logic        s_if_id_flush, s_id_ex_flush, s_me_wb_flush, s_dmem_req, s_halted;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [3:0]  s_stall_cycles;

    int vectors = 0;
    int miscompares = 0;

    logic [4:0] en;
    logic [2:0] fl;
    assign en = {pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en};
    assign fl = {if_id_flush, id_ex_flush, me_wb_flush};

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwr(ex_regwr),
        .ex_mem2reg(ex_mem2reg), .ex_branch_taken(ex_branch_taken),
        .me_rd(me_rd), .me_regwr(me_regwr), .me_mem2reg(me_mem2reg), .me_memwr(me_memwr),
        .wb_rd(wb_rd), .wb_regwr(wb_regwr), .wb_halt(wb_halt), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_me_en(ex_me_en),
        .me_wb_en(me_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .me_wb_flush(me_wb_flush), .dmem_req(dmem_req), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    pipe_ctrl #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwr(ex_regwr),
        .ex_mem2reg(ex_mem2reg), .ex_branch_taken(ex_branch_taken),
        .me_rd(me_rd), .me_regwr(me_regwr), .me_mem2reg(me_mem2reg), .me_memwr(me_memwr),
        .wb_rd(wb_rd), .wb_regwr(wb_regwr), .wb_halt(wb_halt), .dmem_ack(dmem_ack),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en), .ex_me_en(s_ex_me_en),
        .me_wb_en(s_me_wb_en), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .me_wb_flush(s_me_wb_flush), .dmem_req(s_dmem_req), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .halted(s_halted), .stall_cycles(s_stall_cycles)
    );

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regwr = 0; ex_mem2reg = 0; ex_branch_taken = 0;
        me_rd = 0; me_regwr = 0; me_mem2reg = 0; me_memwr = 0;
        wb_rd = 0; wb_regwr = 0; wb_halt = 0; dmem_ack = 0;
    endtask

    task automatic set_load_use();
        ex_mem2reg = 1; ex_regwr = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        ex_rs = 5; me_rd = 5; me_regwr = 1; me_mem2reg = 1;
        #2;
        vectors++;
        if (en !== 5'b00000) begin miscompares++; $display("FAIL reset_en got=%b exp=00000", en); end
        vectors++;
        if (fl !== 3'b111) begin miscompares++; $display("FAIL reset_flush got=%b exp=111", fl); end
        vectors++;
        if ({dmem_req, halted, fwd_a, fwd_b} !== 6'b0) begin
            miscompares++; $display("FAIL reset_misc got=%b exp=000000", {dmem_req, halted, fwd_a, fwd_b});
        end
        vectors++;
        if (stall_cycles !== 32'd0) begin miscompares++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles); end
        tick();
        tick();
        clear_inputs();
        rst = 0;
        #1;
        vectors++;
        if ({en, fl, dmem_req} !== 9'b11111_000_0) begin
            miscompares++; $display("FAIL idle_run got=%b exp=111110000", {en, fl, dmem_req});
        end
    endtask

    task automatic test_load_use();
        tick();
        set_load_use();
        #1;
        vectors++;
        if ({pc_en, if_id_en, ex_me_en, me_wb_en, id_ex_flush, if_id_flush} !== 6'b001110) begin
            miscompares++;
            $display("FAIL load_use got=%b exp=001110", {pc_en, if_id_en, ex_me_en, me_wb_en, id_ex_flush, if_id_flush});
        end
        tick();
        clear_inputs();
        #1;
        vectors++;
        if ({en, fl} !== 8'b11111_000) begin miscompares++; $display("FAIL load_use_next got=%b exp=11111000", {en, fl}); end
        vectors++;
        if (stall_cycles !== 32'd1) begin miscompares++; $display("FAIL load_use_cnt got=%0d exp=1", stall_cycles); end
        // rt path, and a load into $0 is never a hazard
        ex_mem2reg = 1; ex_regwr = 1; ex_rd = 9; id_rt = 9; id_uses_rt = 1;
        #1;
        vectors++;
        if (pc_en !== 1'b0) begin miscompares++; $display("FAIL load_use_rt got=%b exp=0", pc_en); end
        ex_rd = 0; id_rt = 0;
        #1;
        vectors++;
        if (pc_en !== 1'b1) begin miscompares++; $display("FAIL load_use_r0 got=%b exp=1", pc_en); end
        clear_inputs();
    endtask

    task automatic test_branch_priority();
        tick();
        set_load_use();
        ex_branch_taken = 1;
        #1;
        vectors++;
        if ({pc_en, if_id_flush, id_ex_flush} !== 3'b111) begin
            miscompares++; $display("FAIL branch got=%b exp=111", {pc_en, if_id_flush, id_ex_flush});
        end
        tick();
        clear_inputs();
        vectors++;
        if (stall_cycles !== 32'd1) begin miscompares++; $display("FAIL branch_cnt got=%0d exp=1", stall_cycles); end
    endtask

    task automatic test_mem_wait();
        me_mem2reg = 1; dmem_ack = 0;
        for (int c = 0; c < 3; c++) begin
            ex_branch_taken = (c == 1);
            #1;
            vectors++;
            if ({dmem_req, en, fl} !== 9'b1_00001_001) begin
                miscompares++; $display("FAIL mem_wait_c%0d got=%b exp=100001001", c, {dmem_req, en, fl});
            end
            tick();
        end
        ex_branch_taken = 0;
        dmem_ack = 1;
        #1;
        vectors++;
        if ({dmem_req, en, fl} !== 9'b1_11111_000) begin
            miscompares++; $display("FAIL mem_ack got=%b exp=111111000", {dmem_req, en, fl});
        end
        tick();
        clear_inputs();
        #1;
        vectors++;
        if ({dmem_req, en} !== 6'b0_11111) begin miscompares++; $display("FAIL mem_back_run got=%b exp=011111", {dmem_req, en}); end
        vectors++;
        if (stall_cycles !== 32'd4) begin miscompares++; $display("FAIL mem_cnt got=%0d exp=4", stall_cycles); end
        me_memwr = 1; dmem_ack = 1;
        #1;
        vectors++;
        if ({dmem_req, en} !== 6'b1_11111) begin miscompares++; $display("FAIL mem_zero_wait got=%b exp=111111", {dmem_req, en}); end
        tick();
        clear_inputs();
        vectors++;
        if (stall_cycles !== 32'd4) begin miscompares++; $display("FAIL mem_zero_cnt got=%0d exp=4", stall_cycles); end
    endtask

    task automatic test_forwarding();
        ex_rs = 5; me_rd = 5; me_regwr = 1; wb_rd = 5; wb_regwr = 1;
        #1;
        vectors++;
        if (fwd_a !== 2'b10) begin miscompares++; $display("FAIL fwd_me got=%b exp=10", fwd_a); end
        me_regwr = 0;
        #1;
        vectors++;
        if (fwd_a !== 2'b01) begin miscompares++; $display("FAIL fwd_wb got=%b exp=01", fwd_a); end
        ex_rt = 0; me_rd = 0; me_regwr = 1; wb_rd = 0;
        #1;
        vectors++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin miscompares++; $display("FAIL fwd_r0 got=%b exp=0000", {fwd_a, fwd_b}); end
        ex_rt = 7; me_rd = 7; wb_rd = 5;
        #1;
        vectors++;
        if ({fwd_a, fwd_b} !== 4'b0110) begin miscompares++; $display("FAIL fwd_ab got=%b exp=0110", {fwd_a, fwd_b}); end
        clear_inputs();
    endtask

    task automatic test_halt_and_reset();
        logic [31:0] frozen;
        tick();
        wb_halt = 1;
        tick();
        wb_halt = 0;
        frozen = stall_cycles;
        set_load_use();
        me_mem2reg = 1;
        for (int c = 0; c < 10; c++) begin
            #1;
            vectors++;
            if ({halted, dmem_req, en} !== 7'b1_0_00000) begin
                miscompares++; $display("FAIL halt_c%0d got=%b exp=1000000", c, {halted, dmem_req, en});
            end
            tick();
        end
        vectors++;
        if (stall_cycles !== frozen) begin miscompares++; $display("FAIL halt_cnt got=%0d exp=%0d", stall_cycles, frozen); end
        clear_inputs();
        #2;
        rst = 1;
        #1;
        vectors++;
        if ({halted, dmem_req} !== 2'b00 || stall_cycles !== 32'd0) begin
            miscompares++; $display("FAIL halt_async_rst got=%b/%0d exp=00/0", {halted, dmem_req}, stall_cycles);
        end
        tick();
        rst = 0;
        // enter MEM_WAIT, then reset asynchronously mid-cycle
        me_mem2reg = 1;
        tick();
        tick();
        vectors++;
        if (dmem_req !== 1'b1 || stall_cycles !== 32'd2) begin
            miscompares++; $display("FAIL wait_pre_rst got=%b/%0d exp=1/2", dmem_req, stall_cycles);
        end
        #2;
        rst = 1;
        #1;
        vectors++;
        if (dmem_req !== 1'b0 || stall_cycles !== 32'd0) begin
            miscompares++; $display("FAIL wait_async_rst got=%b/%0d exp=0/0", dmem_req, stall_cycles);
        end
        tick();
        me_mem2reg = 0;
        rst = 0;
        #1;
        vectors++;
        if ({dmem_req, en} !== 6'b0_11111) begin miscompares++; $display("FAIL post_rst_run got=%b exp=011111", {dmem_req, en}); end
    endtask

    task automatic test_saturation();
        set_load_use();
        for (int c = 0; c < 20; c++) begin
            if (c == 15) begin
                vectors++;
                if (s_stall_cycles !== 4'd15) begin miscompares++; $display("FAIL sat_reach got=%0d exp=15", s_stall_cycles); end
            end
            tick();
        end
        clear_inputs();
        vectors++;
        if (s_stall_cycles !== 4'd15) begin miscompares++; $display("FAIL sat_stick got=%0d exp=15", s_stall_cycles); end
        vectors++;
        if (stall_cycles !== 32'd20) begin miscompares++; $display("FAIL sat_wide got=%0d exp=20", stall_cycles); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_priority();
        test_mem_wait();
        test_forwarding();
        test_halt_and_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage MIPS pipeline (IF_ID, ID_EX, EX_ME, ME_WB stage registers).
- Generates per-stage write enables and flushes, EX-stage forwarding selects, and the data-memory request handshake.
- Handles load-use bubbles, taken-branch squash, multi-cycle data-memory stalls and a terminal halt.
- Keeps a saturating stall-cycle performance counter.

Parameters:
CNT_W, 32, width of the stall-cycle counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
id_rs, id_rt  in  5 each  source registers of the instruction in ID
id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt
ex_rs, ex_rt  in  5 each  source registers of the instruction in EX
ex_rd  in  5  destination register in EX
ex_regwr, ex_mem2reg  in  1 each  EX control bits
ex_branch_taken  in  1  branch/jump in EX resolved taken
me_rd  in  5  destination register in ME
me_regwr, me_mem2reg, me_memwr  in  1 each  ME control bits
wb_rd  in  5  destination register in WB
wb_regwr  in  1  WB writes the register file
wb_halt  in  1  syscall/halt instruction in WB
dmem_ack  in  1  data memory completes the current access
pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en  out  1 each  stage register load enables
if_id_flush, id_ex_flush, me_wb_flush  out  1 each  load a bubble (all-zero) into the stage register
dmem_req  out  1  data-memory access request
fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 10 ME result, 01 WB result
halted  out  1  pipeline permanently stopped
stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0 while not halted

Behaviour:
- State register: RUN, MEM_WAIT, HALTED. Async reset forces RUN and stall_cycles=0.
- While rst=1:
  - all *_en = 0, all *_flush = 1.
  - dmem_req = 0, fwd_* = 00, halted = 0.
- All other outputs are combinational from the current state and inputs.
- Memory access (mem = me_mem2reg | me_memwr):
  - In RUN, dmem_req = mem.
  - mem=1 with dmem_ack=0: next state MEM_WAIT. pc/if_id/id_ex/ex_me enables = 0; me_wb_en = 1 with me_wb_flush = 1 (bubble into WB).
  - mem=1 with dmem_ack=1: normal advance, zero-wait access.
- MEM_WAIT:
  - dmem_req held at 1; whole pipe frozen as above; ex_branch_taken and load-use ignored.
  - On dmem_ack: all enables = 1, no flush, return to RUN. Exactly one ME_WB capture per access.
- Branch (RUN, no memory stall):
  - ex_branch_taken = 1 gives pc_en = 1 (target load), if_id_flush = 1 and id_ex_flush = 1.
  - Branch squash takes priority over load-use.
- Load-use (RUN, no memory stall, no branch):
  - Condition: ex_mem2reg & ex_regwr & ex_rd != 0 & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)).
  - Response: pc_en = 0, if_id_en = 0, id_ex_flush = 1, ex_me_en = me_wb_en = 1.
  - Lasts exactly one cycle, as the load moves to ME.
- Priority: HALTED > MEM_WAIT or ME stall > branch > load-use > normal (all enables 1, no flush).
- Halt:
  - wb_halt = 1 in RUN: next state HALTED.
  - HALTED: all enables 0, dmem_req = 0, halted = 1 until reset. Counter frozen.
  - wb_halt during MEM_WAIT cannot occur, since WB holds a bubble.
- Forwarding (all states):
  - fwd_a = 10 if me_regwr & me_rd != 0 & me_rd == ex_rs.
  - Else fwd_a = 01 if wb_regwr & wb_rd != 0 & wb_rd == ex_rs.
  - Else fwd_a = 00. ME beats WB. fwd_b is the same, using ex_rt.
  - Register $0 is never forwarded.
- stall_cycles: increments on each clock where pc_en = 0 and state != HALTED; saturates at all-ones, no wrap.
- Async reset mid MEM_WAIT: immediate return to RUN, dmem_req drops in the same cycle. The memory must tolerate an abandoned request.

Decomposition:
- Package pipe_ctrl_pkg:
  - State encoding: RUN = 2'd0, MEM_WAIT = 2'd1, HALTED = 2'd2.
  - Forwarding codes: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_ME = 2'b10.
  - Constant REG_ZERO = 5'd0.
- One sub-module, fwd_unit: purely combinational, computes fwd_a and fwd_b. Instantiated once.

Test Plan:
- Load-use: ex_mem2reg=1, ex_regwr=1, ex_rd=8; id_rs=8, id_uses_rs=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1; stall_cycles += 1.
- Branch plus load-use in the same cycle: ex_branch_taken=1 with the hazard above -> pc_en=1, if_id_flush=1, id_ex_flush=1, stall_cycles unchanged.
- Memory wait: me_mem2reg=1, dmem_ack low for 3 cycles then high:
  - dmem_req=1 for 4 cycles.
  - Front enables 0 for 3 cycles; me_wb_flush=1 for those cycles.
  - RUN after ack; stall_cycles += 3.
  - ex_branch_taken=1 during the wait has no effect.
- Forwarding: ex_rs=5, me_rd=5, me_regwr=1, wb_rd=5, wb_regwr=1 -> fwd_a=10. me_regwr=0 -> fwd_a=01. ex_rt=0 with me_rd=0, me_regwr=1 -> fwd_b=00.
- Halt and reset: wb_halt=1 -> halted=1, all enables 0 and stay so for 10 cycles. Assert rst asynchronously (mid-cycle, also mid MEM_WAIT) -> halted=0, dmem_req=0, stall_cycles=0 immediately.
- Saturation: CNT_W=4, 20 consecutive load-use/memory stall cycles -> stall_cycles sticks at 15.
